// File: rtl/sst_engine_pkg.sv
// Shared types for the save-state engine: FSM state encoding, the index
// slot location and the save-state bus field layout.
// Latency: n/a (types only). Backpressure: n/a.
package sst_engine_pkg;

  // Last slot of the mapper register file; read-only, holds the mapper index.
  localparam int SST_IDX_SLOT = 127;

  typedef enum logic [3:0] {
    IDLE,
    SV_SET,   // save: present slot address to the mapper
    SV_CAP,   // save: capture mapper readback into the buffer
    LD_CHK,   // load: address the index slot on both sides
    LD_CMP,   // load: compare buffered index with live mapper index
    LD_RD,    // load: issue buffer read for the slot
    LD_HOLD,  // load: buffer data arrives, drive it onto the bus
    LD_WAIT,  // load: wait for cpu_m3 and strobe the write
    LD_NXT,   // load: post-write hold clock, advance slot
    FIN
  } sst_eng_st_t;

  // Save-state bus as seen by the mapper.
  typedef struct packed {
    logic       act;
    logic [7:0] addr;
    logic       we_reg;
    logic [7:0] dato;
  } sst_bus_t;

endpackage

// File: rtl/sst_m3_wait.sv
// Waits for cpu_m3 while enabled: strobe on the first cpu_m3 clock, timeout
// after M3_TMO enabled clocks without cpu_m3. Latency: strobe is combinational.
// Backpressure: none; the caller leaves the wait state on strobe or timeout.
// Ports: clk, rst (async, high) | clr: zero the counter | en: waiting |
//        cpu_m3: write window | strobe: write now | timeout: give up now.
module sst_m3_wait
  import sst_engine_pkg::*;
#(
  parameter int M3_TMO = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic cpu_m3,
  output logic strobe,
  output logic timeout
);

  localparam int CW = $clog2(M3_TMO + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !cpu_m3) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The caller exits the wait state on strobe, so it lasts a single clock.
  assign strobe  = en & cpu_m3;
  // cnt counts the clocks already spent waiting; this is the M3_TMO-th one.
  assign timeout = en & ~cpu_m3 & (cnt == CW'(M3_TMO - 1));

endmodule

// File: rtl/sst_engine.sv
// Save-state initiator: copies every mapper slot to the state buffer (save)
// or writes them back inside cpu_m3 windows (load). Latency: save 2/slot,
// load 4/slot with cpu_m3 high. Backpressure: requests ignored while busy.
// Ports: clk, rst (async, high) | save_req, load_req, cpu_m3 |
//        sst_act/sst_addr/sst_we_reg/sst_dato out, sst_di in (mapper) |
//        buf_addr/buf_we/buf_wd out, buf_rd in (buffer, 1-clock read) |
//        busy, done (pulse), err (sticky).
module sst_engine
  import sst_engine_pkg::*;
#(
  parameter int REG_CNT = SST_IDX_SLOT + 1,
  parameter int M3_TMO  = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       save_req,
  input  logic       load_req,
  input  logic       cpu_m3,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [6:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_wd,
  input  logic [7:0] buf_rd,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int SW = $clog2(REG_CNT);
  localparam logic [SW-1:0] LAST    = SW'(REG_CNT - 1);
  localparam logic [SW-1:0] LAST_WR = SW'(REG_CNT - 2);

  sst_eng_st_t   state, state_nxt;
  logic [SW-1:0] slot;
  logic [7:0]    dato_q;
  logic          err_q;
  sst_bus_t      bus;
  logic          req_any;
  logic          idx_ok;
  logic          m3_clr, m3_en, m3_strobe, m3_timeout;

  assign req_any = save_req | load_req;
  // In LD_CMP both sides are addressed at the index slot.
  assign idx_ok  = (buf_rd == sst_di);
  assign m3_clr  = (state == LD_HOLD);
  assign m3_en   = (state == LD_WAIT);

  sst_m3_wait #(.M3_TMO(M3_TMO)) u_m3_wait (
    .clk     (clk),
    .rst     (rst),
    .clr     (m3_clr),
    .en      (m3_en),
    .cpu_m3  (cpu_m3),
    .strobe  (m3_strobe),
    .timeout (m3_timeout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (save_req)      state_nxt = SV_SET;
        else if (load_req) state_nxt = LD_CHK;
      end
      SV_SET:  state_nxt = SV_CAP;
      SV_CAP:  state_nxt = (slot == LAST) ? FIN : SV_SET;
      LD_CHK:  state_nxt = LD_CMP;
      LD_CMP:  state_nxt = idx_ok ? LD_RD : IDLE;
      LD_RD:   state_nxt = LD_HOLD;
      LD_HOLD: state_nxt = LD_WAIT;
      LD_WAIT: begin
        if (m3_strobe)       state_nxt = LD_NXT;
        else if (m3_timeout) state_nxt = IDLE;
      end
      // The index slot is read-only, so the walk ends one slot early.
      LD_NXT:  state_nxt = (slot == LAST_WR) ? FIN : LD_RD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot counter, sticky error and write-data latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot   <= '0;
      err_q  <= 1'b0;
      dato_q <= '0;
    end else begin
      case (state)
        IDLE:    if (req_any) begin slot <= '0; err_q <= 1'b0; end
        SV_CAP:  if (slot != LAST) slot <= slot + SW'(1);
        LD_CMP:  if (!idx_ok) err_q <= 1'b1;
        LD_HOLD: dato_q <= buf_rd;
        LD_WAIT: if (m3_timeout) err_q <= 1'b1;
        LD_NXT:  if (slot != LAST_WR) slot <= slot + SW'(1);
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus      = '0;
    buf_addr = '0;
    buf_we   = 1'b0;
    buf_wd   = '0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      SV_SET: begin
        bus.act  = 1'b1;
        bus.addr = 8'(slot);
      end
      SV_CAP: begin
        bus.act  = 1'b1;
        bus.addr = 8'(slot);
        buf_addr = 7'(slot);
        buf_we   = 1'b1;
        buf_wd   = sst_di;
      end
      LD_CHK, LD_CMP: begin
        bus.act  = 1'b1;
        bus.addr = 8'(LAST);
        buf_addr = 7'(LAST);
      end
      LD_RD: begin
        bus.act  = 1'b1;
        bus.addr = 8'(slot);
        buf_addr = 7'(slot);
      end
      // Buffer data is shown directly while it is being latched so address
      // and data are already settled a full clock before any write strobe.
      LD_HOLD: begin
        bus.act  = 1'b1;
        bus.addr = 8'(slot);
        bus.dato = buf_rd;
        buf_addr = 7'(slot);
      end
      LD_WAIT: begin
        bus.act    = 1'b1;
        bus.addr   = 8'(slot);
        bus.dato   = dato_q;
        bus.we_reg = m3_strobe;
      end
      // Address and data held one clock past the strobe.
      LD_NXT: begin
        bus.act  = 1'b1;
        bus.addr = 8'(slot);
        bus.dato = dato_q;
      end
      FIN: done = 1'b1;
      default: ;
    endcase
  end

  assign sst_act    = bus.act;
  assign sst_addr   = bus.addr;
  assign sst_we_reg = bus.we_reg;
  assign sst_dato   = bus.dato;
  assign err        = err_q;

endmodule

// File: tb/tb_sst_engine.sv
`timescale 1ns/1ps
module tb_sst_engine;
  localparam int REG_CNT = 128;
  localparam int M3_TMO  = 4095;
  localparam int LIMIT   = 6000;

  logic       clk = 1'b0;
  logic       rst, save_req, load_req, cpu_m3;
  logic       sst_act, sst_we_reg;
  logic [7:0] sst_addr, sst_dato, sst_di;
  logic [6:0] buf_addr;
  logic       buf_we;
  logic [7:0] buf_wd, buf_rd;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  // Mapper register file and state buffer models
  logic [7:0] mreg [0:127];
  logic [7:0] bmem [0:127];
  // Initial contents used to derive expectations
  logic [7:0] init_m [0:127];
  logic [7:0] init_b [0:127];

  int wr_cnt = 0;
  int m3_mode = 0;   // 0 always high, 1 high 1-in-12, 2 never, 3 random
  int m3_ph = 0;

  logic       prev_we = 1'b0, prev_done = 1'b0;
  logic [7:0] prev_addr = '0, prev_dato = '0;

  typedef struct {
    bit         save;
    int         m3;
    logic [7:0] bidx;
    logic [7:0] midx;
    bit         exp_err;
    bit         exp_done;
    int         exp_clk;   // clock of done / busy fall (request clock = 1); 0 = untimed
    int         exp_wr;
    bit         poke;      // pulse the other request mid-operation
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  sst_engine #(.REG_CNT(REG_CNT), .M3_TMO(M3_TMO)) dut (
    .clk(clk), .rst(rst), .save_req(save_req), .load_req(load_req), .cpu_m3(cpu_m3),
    .sst_act(sst_act), .sst_addr(sst_addr), .sst_we_reg(sst_we_reg), .sst_dato(sst_dato),
    .sst_di(sst_di), .buf_addr(buf_addr), .buf_we(buf_we), .buf_wd(buf_wd), .buf_rd(buf_rd),
    .busy(busy), .done(done), .err(err)
  );

  assign sst_di = mreg[sst_addr[6:0]];

  always @(posedge clk) begin
    if (buf_we) bmem[buf_addr] <= buf_wd;
    buf_rd <= bmem[buf_addr];
    if (sst_we_reg) mreg[sst_addr[6:0]] <= sst_dato;
  end

  always @(posedge clk) begin
    #1;
    case (m3_mode)
      0: cpu_m3 = 1'b1;
      1: begin cpu_m3 = (m3_ph == 0); m3_ph = (m3_ph + 1) % 12; end
      2: cpu_m3 = 1'b0;
      default: cpu_m3 = ($urandom_range(3) != 0);
    endcase
  end

  // Bus invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (sst_we_reg) begin
      wr_cnt++;
      checks++;
      if (!cpu_m3 || prev_we || !sst_act || sst_addr == 8'd127 ||
          sst_addr != prev_addr || sst_dato != prev_dato) begin
        errors++;
        $display("FAIL strobe: addr=%0d dato=%h m3=%b act=%b prev_we=%b prev_addr=%0d prev_dato=%h",
                 sst_addr, sst_dato, cpu_m3, sst_act, prev_we, prev_addr, prev_dato);
      end
    end
    if (busy && !done) begin
      checks++;
      if (!sst_act) begin
        errors++;
        $display("FAIL act_gap: sst_act=0 while busy at %0t", $time);
      end
    end
    if (done && prev_done) begin
      errors++;
      $display("FAIL done_width: done high two clocks at %0t", $time);
    end
    prev_we   = sst_we_reg;
    prev_addr = sst_addr;
    prev_dato = sst_dato;
    prev_done = done;
  end

  task preload();
    for (int n = 0; n < REG_CNT; n++) begin
      mreg[n] <= init_m[n];
      bmem[n] <= init_b[n];
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic run_op(input bit s, input bit l, input bit poke,
                        output int clkn, output bit got_done, output bit got_err);
    bit fin;
    fin = 0;
    got_done = 0;
    @(posedge clk); #1; save_req = s; load_req = l; clkn = 1;
    @(posedge clk); #1; save_req = 0; load_req = 0;
    while (!fin && clkn < LIMIT) begin
      @(negedge clk);
      clkn++;
      if (clkn == 2) check("start_busy_errclr", {30'd0, busy, err}, 2);
      if (poke && clkn == 20) begin save_req = !s; load_req = s; end
      if (poke && clkn == 21) begin save_req = 0; load_req = 0; end
      if (done) begin got_done = 1; fin = 1; end
      else if (!busy) fin = 1;
    end
    if (!fin) begin
      errors++;
      $display("FAIL op_timeout: no completion within %0d clocks", LIMIT);
    end
    got_err = err;
    @(negedge clk);
    check("idle_after", {29'd0, busy, done, sst_act}, 0);
  endtask

  // Expected contents: save copies mapper to buffer; a good load copies
  // buffer slots 0..REG_CNT-2 into the mapper; anything else leaves the mapper alone.
  task automatic check_data(input string name, input bit s, input bit ok);
    int bad, first;
    logic [7:0] em, eb;
    bad = 0;
    first = -1;
    for (int n = 0; n < REG_CNT; n++) begin
      em = (!s && ok && n < REG_CNT - 1) ? init_b[n] : init_m[n];
      eb = s ? init_m[n] : init_b[n];
      if (mreg[n] !== em || bmem[n] !== eb) begin
        if (bad == 0) first = n;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad slots, first %0d reg=%h buf=%h", name, bad, first,
               mreg[first], bmem[first]);
    end
  endtask

  initial begin
    int  clkn;
    bit  gd, ge, s, prev_err, found;
    rst = 1'b1; save_req = 0; load_req = 0;

    tbl[0] = '{1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 2*REG_CNT + 2,     0,           1'b1};
    tbl[1] = '{1'b0, 0, 8'hC6, 8'hC6, 1'b0, 1'b1, 4*(REG_CNT-1) + 4, REG_CNT - 1, 1'b1};
    tbl[2] = '{1'b0, 1, 8'hC6, 8'hC6, 1'b0, 1'b1, 0,                 REG_CNT - 1, 1'b0};
    tbl[3] = '{1'b0, 0, 8'h03, 8'h04, 1'b1, 1'b0, 4,                 0,           1'b0};
    tbl[4] = '{1'b0, 2, 8'hC6, 8'hC6, 1'b1, 1'b0, 6 + M3_TMO,        0,           1'b0};
    tbl[5] = '{1'b1, 1, 8'h00, 8'h00, 1'b0, 1'b1, 2*REG_CNT + 2,     0,           1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({sst_act, sst_addr, sst_we_reg, sst_dato, buf_addr,
                                 buf_we, buf_wd, busy, done, err} != 37'd0), 0);
    @(posedge clk); #1; rst = 1'b0;

    prev_err = 0;
    for (int r = 0; r < 6; r++) begin
      check("err_sticky", int'(err), int'(prev_err));
      m3_mode = tbl[r].m3;
      m3_ph = 0;
      for (int n = 0; n < REG_CNT; n++) begin
        if (tbl[r].save) begin
          init_m[n] = 8'(n ^ 'h5A);
          init_b[n] = 8'hFF;
        end else begin
          init_m[n] = (n == REG_CNT - 1) ? tbl[r].midx : ~8'(n + 1);
          init_b[n] = (n == REG_CNT - 1) ? tbl[r].bidx : 8'(n + 1);
        end
      end
      preload();
      wr_cnt = 0;
      run_op(tbl[r].save, !tbl[r].save, tbl[r].poke, clkn, gd, ge);
      check($sformatf("row%0d_err", r), int'(ge), int'(tbl[r].exp_err));
      check($sformatf("row%0d_done", r), int'(gd), int'(tbl[r].exp_done));
      if (tbl[r].exp_clk != 0) check($sformatf("row%0d_clock", r), clkn, tbl[r].exp_clk);
      check($sformatf("row%0d_writes", r), wr_cnt, tbl[r].exp_wr);
      check_data($sformatf("row%0d_data", r), tbl[r].save, !tbl[r].exp_err);
      prev_err = tbl[r].exp_err;
    end

    // Randomized contents, alternating save/load, random cpu_m3 on later loads
    for (int it = 0; it < 6; it++) begin
      s = (it % 2 == 0);
      m3_mode = (it < 2) ? 0 : 3;
      for (int n = 0; n < REG_CNT; n++) begin
        init_m[n] = 8'($urandom);
        init_b[n] = 8'($urandom);
      end
      if (!s) init_b[REG_CNT-1] = init_m[REG_CNT-1];
      preload();
      wr_cnt = 0;
      run_op(s, !s, 1'b0, clkn, gd, ge);
      check($sformatf("rnd%0d_ok", it), int'({gd, ge}), 2);
      if (s)                 check($sformatf("rnd%0d_clock", it), clkn, 2*REG_CNT + 2);
      else if (m3_mode == 0) check($sformatf("rnd%0d_clock", it), clkn, 4*(REG_CNT-1) + 4);
      check($sformatf("rnd%0d_writes", it), wr_cnt, s ? 0 : REG_CNT - 1);
      check_data($sformatf("rnd%0d_data", it), s, 1'b1);
    end

    // Reset in the middle of a save, at slot 40
    m3_mode = 0;
    for (int n = 0; n < REG_CNT; n++) begin
      init_m[n] = 8'(n ^ 'h5A);
      init_b[n] = 8'hFF;
    end
    preload();
    @(posedge clk); #1; save_req = 1;
    @(posedge clk); #1; save_req = 0;
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (sst_act && sst_addr == 8'd40) found = 1;
    end
    check("reach_slot40", int'(found), 1);
    #1; rst = 1'b1; #1;
    check("async_reset_outputs", int'({sst_act, sst_addr, sst_we_reg, sst_dato, buf_addr,
                                       buf_we, buf_wd, busy, done, err} != 37'd0), 0);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    check("partial_buf_39", int'(bmem[39]), int'(init_m[39]));
    check("partial_buf_40", int'(bmem[40]), 'hFF);
    check("partial_buf_100", int'(bmem[100]), 'hFF);

    // Both requests together: save wins
    wr_cnt = 0;
    run_op(1'b1, 1'b1, 1'b0, clkn, gd, ge);
    check("both_req_done", int'({gd, ge}), 2);
    check("both_req_clock", clkn, 2*REG_CNT + 2);
    check("both_req_writes", wr_cnt, 0);
    check_data("both_req_data", 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
